mem_lsu_stage: RTL and testbench
================================

// Module: mem_lsu_stage
// PURPOSE
//  Parametrised memory stage between EX and WB. Executes loads/stores over a req/gnt/rvalid
//  memory port with variable latency, sign/zero extension and byte-lane alignment.
//  Passes ALU/jump results through a DEPTH-entry output FIFO, decoupling WB back-pressure.
//  Flags misaligned accesses and illegal funct3 instead of accessing memory.
// PARAMETERS
//  DEPTH  2  output FIFO entries (>=1)
// PORTS
//  clk           in   1   clock
//  rstn_i        in   1   asynchronous, active-low reset
//  halt_i        in   1   freeze request (honoured in IDLE only)
//  valid_i       in   1   EX entry valid
//  ack_o         out  1   EX entry consumed this cycle
//  instr_i       in   32  instruction
//  result_i      in   32  ALU result / effective address
//  rs2_i         in   32  store data
//  pc_i          in   32  instruction PC
//  MEM_req_o     out  1   memory request, held until MEM_gnt_i
//  MEM_gnt_i     in   1   request accepted
//  MEM_addr_o    out  32  word-aligned address {addr[31:2],2'b00}
//  MEM_we_o      out  1   write request
//  MEM_be_o      out  4   byte enables, shifted by addr[1:0]
//  MEM_data_o    out  32  store data, shifted to byte lane
//  MEM_rvalid_i  in   1   read data valid (>=1 cycle after gnt)
//  MEM_data_i    in   32  read data word
//  ack_i         in   1   WB pops head entry
//  valid_o       out  1   FIFO not empty
//  instr_o       out  32  head instruction
//  data_o        out  32  head data
//  err_o         out  1   head entry faulted (misaligned / illegal funct3)
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, count 0. Outputs ack_o/valid_o/MEM_req_o/MEM_we_o/err_o 0;
//   MEM_be_o 0; instr_o/data_o/MEM_addr_o/MEM_data_o 0.
//  FSM IDLE/REQ/WAIT_R.
//  IDLE: accepts when valid_i && !halt_i && slot free:
//   slot free = count<DEPTH, or count==DEPTH && ack_i for non-memory ops only.
//   On accept: ack_o=1 in the same cycle.
//    LOAD/STORE OK: capture instr, address, store data; go to REQ.
//    LOAD/STORE faulting: push {instr,0,err=1}; stay in IDLE; no memory access.
//    AUIPC/JAL/JALR: push {instr,pc_i+4}. Others: push {instr,result_i}.
//  REQ: MEM_req_o=1; addr/we/be/data stable until gnt.
//   gnt on store: push {instr,0}; go to IDLE.
//   gnt on load: go to WAIT_R.
//  WAIT_R: MEM_req_o=0. rvalid: push extracted data; go to IDLE.
//   Extraction: byte/half selected by addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend.
//  Faults:
//   misaligned = LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
//   illegal funct3 = load 011/110/111, store 1xx/011.
//  Store lanes: SB be=0001<<a, SH be=0011<<a, SW be=1111.
//   Data = rs2 replicated per size (b x4, h x2).
//  Latency: ALU/jump valid_o 1 cycle after ack_o.
//   Load: valid_o 1 cycle after rvalid. Store: valid_o 1 cycle after gnt.
//  FIFO: push+pop same cycle keeps count; pop when empty ignored. Pointers wrap modulo DEPTH.
//  halt_i in IDLE: no accept, FIFO push blocked, pops still allowed.
//   In REQ/WAIT_R halt_i is ignored until the transaction completes (memory protocol never stalled).
//  Slot reserved at accept: no pushes occur during REQ/WAIT_R, so completion always has room.
//  Reset mid-transaction: immediate return to IDLE. An in-flight rvalid after reset is ignored.
// STRUCTURE
//  mem_pkg: opcode and funct3 constants, state_e enum, out_entry_t {instr,data,err},
//   functions load_extract() and store_lanes().
//  Sub-module mem_out_fifo #(DEPTH): synchronous FIFO of out_entry_t with count output.
//  Top: FSM, request registers and push mux.
// TESTING
//  1. ADD result 0x1234, ack_i=1 -> ack_o same cycle; next cycle valid_o, data_o=0x1234.
//  2. LBU @0x...03, gnt same cycle, rvalid 3 cycles later with 0x80FF_0000 -> data_o=0x80.
//     LB same stimulus -> data_o=0xFFFFFF80.
//  3. SH @0x102, rs2=0xABCD -> MEM_addr_o=0x100, be=1100, data_o_mem=0xABCDABCD;
//     gnt delayed 4 cycles with req held stable.
//  4. LW @0x101 -> no MEM_req_o; valid_o with err_o=1, data_o=0. Next instruction still accepted.
//  5. DEPTH=2, ack_i=0, 3 ALU ops -> two acked, third held (ack_o=0).
//     ack_i=1 -> third accepted the same cycle as the pop.
//  6. halt_i during WAIT_R -> rvalid still captured.
//     halt_i in IDLE with valid_i -> ack_o=0. rstn_i low in REQ -> IDLE, valid_o=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the LSU memory stage: opcodes, FSM states, the
// output-FIFO entry layout and the byte-lane arithmetic for loads and stores.
package mem_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_R
    } state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] data;
        logic        err;
    } out_entry_t;

    // funct3[1:0] encodes the access size for both loads and stores (byte/half/word).
    function automatic logic access_fault(input logic is_store, input logic [2:0] f3,
                                          input logic [1:0] off);
        logic illegal;
        logic misaligned;
        if (is_store) begin
            illegal = f3[2] || (f3 == 3'b011);
        end else begin
            illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        misaligned = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
        return illegal || misaligned;
    endfunction

    function automatic logic [3:0] store_lanes(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] rs2);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{rs2[7:0]}};
            2'b01:   d = {2{rs2[15:0]}};
            default: d = rs2;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (f3)
            F3_B:    res = {{24{sh[7]}}, sh[7:0]};
            F3_H:    res = {{16{sh[15]}}, sh[15:0]};
            F3_BU:   res = {24'h0, sh[7:0]};
            F3_HU:   res = {16'h0, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_out_fifo.sv
// Synchronous FIFO of completed LSU results; exposes the head entry and the
// current fill level so the stage can decide whether it may accept work.
module mem_out_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rstn_i,
    input  logic                           push_i,
    input  out_entry_t                     entry_i,
    input  logic                           pop_i,
    output out_entry_t                     head_o,
    output logic [$clog2(DEPTH + 1) - 1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    out_entry_t    mem_q [DEPTH];
    logic [PW-1:0] rdPtr_q;
    logic [PW-1:0] wrPtr_q;
    logic [CW-1:0] count_q;
    logic          doPush;
    logic          doPop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign doPop  = pop_i && (count_q != '0);
    assign doPush = push_i && ((count_q != CW'(DEPTH)) || doPop);

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= entry_i;
                wrPtr_q        <= nextPtr(wrPtr_q);
            end
            if (doPop) begin
                rdPtr_q <= nextPtr(rdPtr_q);
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mem_lsu_stage.sv
// Memory stage between EX and WB: runs loads/stores over a req/gnt/rvalid port
// and queues every completed instruction into a small output FIFO for WB.
module mem_lsu_stage
    import mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        halt_i,
    input  logic        valid_i,
    output logic        ack_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] result_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] pc_i,
    output logic        MEM_req_o,
    input  logic        MEM_gnt_i,
    output logic [31:0] MEM_addr_o,
    output logic        MEM_we_o,
    output logic [3:0]  MEM_be_o,
    output logic [31:0] MEM_data_o,
    input  logic        MEM_rvalid_i,
    input  logic [31:0] MEM_data_i,
    input  logic        ack_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] data_o,
    output logic        err_o
);

    localparam int CW = $clog2(DEPTH + 1);

    state_e        state_q, state_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic          push;
    out_entry_t    pushEntry;
    out_entry_t    head;
    logic [CW-1:0] count;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          isLoad, isStore, isMem, isLink, fault, slotFree;

    assign opcode  = instr_i[6:0];
    assign funct3  = instr_i[14:12];
    assign isLoad  = (opcode == OPC_LOAD);
    assign isStore = (opcode == OPC_STORE);
    assign isMem   = isLoad || isStore;
    assign isLink  = (opcode == OPC_AUIPC) || (opcode == OPC_JAL) || (opcode == OPC_JALR);
    assign fault   = access_fault(isStore, funct3, result_i[1:0]);

    // Memory ops need a genuinely free slot: their completion push may land
    // in a cycle where WB does not pop, so they cannot borrow a slot being freed.
    assign slotFree = (count < CW'(DEPTH)) || (!isMem && ack_i);

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            be_q    <= be_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        be_d      = be_q;
        ack_o     = 1'b0;
        push      = 1'b0;
        pushEntry = '0;
        case (state_q)
            ST_IDLE: begin
                if (valid_i && !halt_i && slotFree) begin
                    ack_o = 1'b1;
                    if (isMem && !fault) begin
                        instr_d = instr_i;
                        addr_d  = result_i;
                        we_d    = isStore;
                        be_d    = store_lanes(funct3[1:0], result_i[1:0]);
                        wdata_d = isStore ? store_data(funct3[1:0], rs2_i) : '0;
                        state_d = ST_REQ;
                    end else if (isMem) begin
                        push      = 1'b1;
                        pushEntry = '{instr: instr_i, data: 32'h0, err: 1'b1};
                    end else begin
                        push      = 1'b1;
                        pushEntry = '{instr: instr_i, data: isLink ? pc_i + 32'd4 : result_i,
                                      err: 1'b0};
                    end
                end
            end
            ST_REQ: begin
                if (MEM_gnt_i) begin
                    if (we_q) begin
                        push      = 1'b1;
                        pushEntry = '{instr: instr_q, data: 32'h0, err: 1'b0};
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_R;
                    end
                end
            end
            ST_WAIT_R: begin
                if (MEM_rvalid_i) begin
                    push      = 1'b1;
                    pushEntry = '{instr: instr_q,
                                  data:  load_extract(instr_q[14:12], addr_q[1:0], MEM_data_i),
                                  err:   1'b0};
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    mem_out_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rstn_i (rstn_i),
        .push_i (push),
        .entry_i(pushEntry),
        .pop_i  (ack_i),
        .head_o (head),
        .count_o(count)
    );

    assign MEM_req_o  = (state_q == ST_REQ);
    assign MEM_addr_o = MEM_req_o ? {addr_q[31:2], 2'b00} : '0;
    assign MEM_we_o   = MEM_req_o && we_q;
    assign MEM_be_o   = MEM_req_o ? be_q : '0;
    assign MEM_data_o = MEM_req_o ? wdata_q : '0;

    // Stale FIFO storage is hidden so an empty stage presents all-zero outputs.
    assign valid_o = (count != '0);
    assign instr_o = valid_o ? head.instr : '0;
    assign data_o  = valid_o ? head.data : '0;
    assign err_o   = valid_o && head.err;

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Self-checking bench for mem_lsu_stage: directed scenarios followed by random
// traffic, all compared against a queue-based behavioural model of the stage.
module tb_mem_lsu_stage;

    localparam int DEPTH = 2;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_ALU   = 7'h33;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_LUI   = 7'h37;

    logic        clk;
    logic        rstn_i;
    logic        halt_i;
    logic        valid_i;
    logic        ack_o;
    logic [31:0] instr_i;
    logic [31:0] result_i;
    logic [31:0] rs2_i;
    logic [31:0] pc_i;
    logic        MEM_req_o;
    logic        MEM_gnt_i;
    logic [31:0] MEM_addr_o;
    logic        MEM_we_o;
    logic [3:0]  MEM_be_o;
    logic [31:0] MEM_data_o;
    logic        MEM_rvalid_i;
    logic [31:0] MEM_data_i;
    logic        ack_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] data_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] data;
        logic        err;
    } expEntry_t;

    expEntry_t   expQ[$];
    bit          busy;
    bit          granted;
    bit          tStore;
    logic [31:0] tInstr;
    logic [31:0] tAddr;
    logic [31:0] tRs2;

    mem_lsu_stage #(
        .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .halt_i      (halt_i),
        .valid_i     (valid_i),
        .ack_o       (ack_o),
        .instr_i     (instr_i),
        .result_i    (result_i),
        .rs2_i       (rs2_i),
        .pc_i        (pc_i),
        .MEM_req_o   (MEM_req_o),
        .MEM_gnt_i   (MEM_gnt_i),
        .MEM_addr_o  (MEM_addr_o),
        .MEM_we_o    (MEM_we_o),
        .MEM_be_o    (MEM_be_o),
        .MEM_data_o  (MEM_data_o),
        .MEM_rvalid_i(MEM_rvalid_i),
        .MEM_data_i  (MEM_data_i),
        .ack_i       (ack_i),
        .valid_o     (valid_o),
        .instr_o     (instr_o),
        .data_o      (data_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mkInstr(input logic [6:0] op, input logic [2:0] f3);
        return {17'h0, f3, 5'd1, op};
    endfunction

    // Access is legal when funct3 names a real size and the address is a multiple of it.
    function automatic bit isFault(input bit isSt, input logic [2:0] f3, input logic [31:0] a);
        int bytes;
        if (isSt) begin
            if (f3 > 3'd2) return 1'b1;
        end else if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
            return 1'b1;
        end
        bytes = 1 << f3[1:0];
        return (int'(a[1:0]) % bytes) != 0;
    endfunction

    function automatic logic [31:0] expLoad(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
        logic [31:0] v;
        logic [31:0] mask;
        int          bytes;
        bytes = 1 << f3[1:0];
        if (bytes == 4) return w;
        mask = (32'h1 << (8 * bytes)) - 32'h1;
        v    = (w >> (8 * int'(off))) & mask;
        if (!f3[2] && v[8 * bytes - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic modelStep();
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] eBe;
        logic [31:0] eData;
        bit          isLd, isSt, isMem, flt, slot, expAck;
        int          size;
        int          bytes;
        op     = instr_i[6:0];
        f3     = instr_i[14:12];
        isLd   = (op == OP_LOAD);
        isSt   = (op == OP_STORE);
        isMem  = isLd || isSt;
        flt    = isFault(isSt, f3, result_i);
        size   = expQ.size();
        slot   = (size < DEPTH) || (!isMem && ack_i && size == DEPTH);
        expAck = !busy && valid_i && !halt_i && slot;

        checkOutput("ack_o", ack_o, expAck);
        checkOutput("MEM_req_o", MEM_req_o, busy && !granted);
        checkOutput("valid_o", valid_o, size != 0);
        if (size != 0) begin
            checkOutput("instr_o", instr_o, expQ[0].instr);
            checkOutput("data_o", data_o, expQ[0].data);
            checkOutput("err_o", err_o, expQ[0].err);
        end
        if (busy && !granted) begin
            checkOutput("MEM_addr_o", MEM_addr_o, tAddr & ~32'h3);
            checkOutput("MEM_we_o", MEM_we_o, tStore);
            if (tStore) begin
                bytes = 1 << tInstr[13:12];
                eBe   = (bytes == 4) ? 32'hF : (((1 << bytes) - 1) << tAddr[1:0]);
                eData = (bytes == 1) ? tRs2[7:0] * 32'h01010101 :
                        (bytes == 2) ? tRs2[15:0] * 32'h00010001 : tRs2;
                checkOutput("MEM_be_o", MEM_be_o, eBe);
                checkOutput("MEM_data_o", MEM_data_o, eData);
            end
        end

        if (ack_i && size != 0) void'(expQ.pop_front());
        if (expAck) begin
            if (isMem && !flt) begin
                busy    = 1'b1;
                granted = 1'b0;
                tInstr  = instr_i;
                tAddr   = result_i;
                tRs2    = rs2_i;
                tStore  = isSt;
            end else if (isMem) begin
                expQ.push_back('{instr_i, 32'h0, 1'b1});
            end else if (op inside {OP_AUIPC, OP_JAL, OP_JALR}) begin
                expQ.push_back('{instr_i, pc_i + 32'd4, 1'b0});
            end else begin
                expQ.push_back('{instr_i, result_i, 1'b0});
            end
        end else if (busy && !granted && MEM_gnt_i) begin
            if (tStore) begin
                expQ.push_back('{tInstr, 32'h0, 1'b0});
                busy = 1'b0;
            end else begin
                granted = 1'b1;
            end
        end else if (busy && granted && MEM_rvalid_i) begin
            expQ.push_back('{tInstr, expLoad(tInstr[14:12], tAddr[1:0], MEM_data_i), 1'b0});
            busy = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] res,
                                 input logic [31:0] r2, input logic [31:0] pc, input logic h,
                                 input logic ak, input logic g, input logic rv,
                                 input logic [31:0] rd);
        @(negedge clk);
        valid_i      = v;
        instr_i      = ins;
        result_i     = res;
        rs2_i        = r2;
        pc_i         = pc;
        halt_i       = h;
        ack_i        = ak;
        MEM_gnt_i    = g;
        MEM_rvalid_i = rv;
        MEM_data_i   = rd;
        #1;
        modelStep();
    endtask

    task automatic idleCycle(input logic ak);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, ak, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rstn_i       = 1'b0;
        valid_i      = 1'b0;
        halt_i       = 1'b0;
        ack_i        = 1'b0;
        MEM_gnt_i    = 1'b0;
        MEM_rvalid_i = 1'b0;
        #1;
        checkOutput("rst_ack_o", ack_o, 1'b0);
        checkOutput("rst_valid_o", valid_o, 1'b0);
        checkOutput("rst_req_o", MEM_req_o, 1'b0);
        checkOutput("rst_be_o", MEM_be_o, 4'h0);
        checkOutput("rst_addr_o", MEM_addr_o, 32'h0);
        checkOutput("rst_data_o", data_o, 32'h0);
        checkOutput("rst_instr_o", instr_o, 32'h0);
        checkOutput("rst_err_o", err_o, 1'b0);
        expQ.delete();
        busy    = 1'b0;
        granted = 1'b0;
        @(negedge clk);
        rstn_i = 1'b1;
    endtask

    initial begin
        logic [31:0] addI;
        logic [2:0]  ldF3 [2];
        logic [31:0] ldExp [2];

        rstn_i       = 1'b0;
        halt_i       = 1'b0;
        valid_i      = 1'b0;
        instr_i      = '0;
        result_i     = '0;
        rs2_i        = '0;
        pc_i         = '0;
        MEM_gnt_i    = 1'b0;
        MEM_rvalid_i = 1'b0;
        MEM_data_i   = '0;
        ack_i        = 1'b0;
        busy         = 1'b0;
        granted      = 1'b0;
        tStore       = 1'b0;
        tInstr       = '0;
        tAddr        = '0;
        tRs2         = '0;
        addI         = mkInstr(OP_ALU, 3'd0);
        doReset();

        // ALU pass-through
        applyStimulus(1'b1, addI, 32'h1234, 32'h0, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("t1_ack", ack_o, 1'b1);
        idleCycle(1'b1);
        checkOutput("t1_valid", valid_o, 1'b1);
        checkOutput("t1_data", data_o, 32'h1234);

        // LBU / LB from the top byte lane
        ldF3[0] = 3'b100; ldExp[0] = 32'h0000_0080;
        ldF3[1] = 3'b000; ldExp[1] = 32'hFFFF_FF80;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, mkInstr(OP_LOAD, ldF3[k]), 32'h0000_0203, 32'h0, 32'h0, 1'b0,
                          1'b1, 1'b0, 1'b0, 32'h0);
            applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            idleCycle(1'b1);
            idleCycle(1'b1);
            applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80FF_0000);
            idleCycle(1'b1);
            checkOutput("t2_valid", valid_o, 1'b1);
            checkOutput("t2_data", data_o, ldExp[k]);
        end

        // SH with delayed grant
        applyStimulus(1'b1, mkInstr(OP_STORE, 3'b001), 32'h102, 32'h0000_ABCD, 32'h0, 1'b0,
                      1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) idleCycle(1'b1);
        checkOutput("t3_req", MEM_req_o, 1'b1);
        checkOutput("t3_addr", MEM_addr_o, 32'h100);
        checkOutput("t3_be", MEM_be_o, 4'b1100);
        checkOutput("t3_wdata", MEM_data_o, 32'hABCD_ABCD);
        checkOutput("t3_we", MEM_we_o, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        idleCycle(1'b1);
        checkOutput("t3_valid", valid_o, 1'b1);

        // Misaligned LW faults without touching memory
        applyStimulus(1'b1, mkInstr(OP_LOAD, 3'b010), 32'h101, 32'h0, 32'h0, 1'b0, 1'b0,
                      1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, addI, 32'h55, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("t4_req", MEM_req_o, 1'b0);
        checkOutput("t4_err", err_o, 1'b1);
        checkOutput("t4_data", data_o, 32'h0);
        checkOutput("t4_next_ack", ack_o, 1'b1);
        idleCycle(1'b1);

        // FIFO full back-pressure, then accept alongside a pop
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, addI, 32'h10 + k, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        end
        checkOutput("t5_held", ack_o, 1'b0);
        applyStimulus(1'b1, addI, 32'h12, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("t5_accept_on_pop", ack_o, 1'b1);
        for (int k = 0; k < 3; k++) idleCycle(1'b1);

        // halt during WAIT_R, halt in IDLE, reset in REQ, stale rvalid after reset
        applyStimulus(1'b1, mkInstr(OP_LOAD, 3'b010), 32'h200, 32'h0, 32'h0, 1'b0, 1'b1,
                      1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
        idleCycle(1'b1);
        checkOutput("t6_halt_rvalid", data_o, 32'hCAFE_F00D);
        applyStimulus(1'b1, addI, 32'h77, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("t6_halt_idle", ack_o, 1'b0);
        applyStimulus(1'b1, mkInstr(OP_LOAD, 3'b010), 32'h300, 32'h0, 32'h0, 1'b0, 1'b0,
                      1'b0, 1'b0, 32'h0);
        idleCycle(1'b0);
        doReset();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        idleCycle(1'b0);
        checkOutput("t6_stale_rvalid", valid_o, 1'b0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] r;
            logic [6:0]  op;
            logic        g;
            logic        rv;
            r = $urandom();
            case ($urandom_range(0, 7))
                0:       op = OP_LOAD;
                1:       op = OP_STORE;
                2:       op = OP_ALU;
                3:       op = OP_IMM;
                4:       op = OP_AUIPC;
                5:       op = OP_JAL;
                6:       op = OP_JALR;
                default: op = OP_LUI;
            endcase
            g  = busy && !granted && ($urandom_range(0, 2) == 0);
            rv = busy && granted && ($urandom_range(0, 2) == 0);
            applyStimulus(1'($urandom_range(0, 1)), {r[31:7], op}, $urandom(), $urandom(),
                          $urandom(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0),
                          g, rv, $urandom());
            if ($urandom_range(0, 499) == 0) doReset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
